// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit bounds and a legality check.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_t;

    // A nibble is a legal BCD digit when it does not exceed 9.
    function automatic logic bcd_valid(input bcd_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register: load, step up/down with 9<->0 rollover,
// and flags for the cascade logic in the parent.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic up,
    input  logic ld,
    input  bcd_t d,
    output bcd_t q,
    output logic at_max,
    output logic at_min
);

    // Digit register; load outranks step, rollover stays within 0..9.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= BCD_MIN;
        end else if (ld) begin
            q <= d;
        end else if (step) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    assign at_max = (q == BCD_MAX);
    assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD counter: cascade of bcd_digit instances with enable,
// direction, validated parallel load, terminal count and sticky wrap flag.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    input  logic                clr_wrap,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic              din_ok;
    logic              ld_ok;
    logic              all_max;
    logic              all_min;
    logic              run_max;
    logic              run_min;

    // Load is accepted only if every nibble of din is a legal digit.
    always_comb begin
        din_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bcd_valid(din[4*k +: 4])) din_ok = 1'b0;
        end
    end

    assign ld_ok = load & din_ok;

    // Ripple the "all lower digits at terminal" condition to build per-digit steps.
    // Any load request, accepted or rejected, suppresses counting that cycle.
    always_comb begin
        run_max = 1'b1;
        run_min = 1'b1;
        step    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            step[k] = en & ~load & (up ? run_max : run_min);
            run_max = run_max & at_max[k];
            run_min = run_min & at_min[k];
        end
        all_max = run_max;
        all_min = run_min;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .step   (step[g]),
                .up     (up),
                .ld     (ld_ok),
                .d      (din[4*g +: 4]),
                .q      (count[4*g +: 4]),
                .at_max (at_max[g]),
                .at_min (at_min[g])
            );
        end
    endgenerate

    // Combinational so a following counter can chain off it without delay.
    assign tc = en & (up ? all_max : all_min);

    // Wrap is set by an enabled step off the terminal value; set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= (tc & ~load) | (wrap & ~clr_wrap);
        end
    end

    // One-cycle flag for a rejected load; recomputed every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & ~din_ok;
        end
    end

endmodule
